persp_param_latch: RTL
======================

# persp_param_latch

Frame-synchronous parameter stage between `perspective_params` and `vga`.

- Accepts a new set of nine inverse-perspective coefficients from `perspective_params` over a valid/ready handshake.
- Computes the three end-of-line rewind terms (`dec_*_horiz`) with a sequential shift-add multiplier.
- Presents a consistent coefficient set to `vga`, updated only at a frame boundary, so no frame is rendered with mixed old and new coefficients.

## Interface

Parameters:
- `H_STEPS`, 800: per-line accumulation count multiplied into the rewind terms.
- `MUL_W`, 10: bit width of `H_STEPS`; sets the multiply iteration count.

Ports:
- `vclock`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  `in_p*` hold a new coefficient set.
- `in_ready`  out  1  block can accept a set this cycle.
- `in_p1`..`in_p9`  in  68/69/79/68/69/79/59/60/71, signed  new coefficients.
- `frame_start`  in  1  one-cycle pulse, high at `hcount==798 && vcount==523` (one cycle before `vga` frame reload).
- `p1_inv`..`p9_inv`  out  same widths as `in_p*`, signed  published coefficients.
- `dec_numx_horiz`  out  79 signed  `H_STEPS * p1_inv`.
- `dec_numy_horiz`  out  79 signed  `H_STEPS * p4_inv`.
- `dec_denom_horiz`  out  71 signed  `H_STEPS * p7_inv`.
- `params_loaded`  out  1  high once any set has been published.
- `param_update`  out  1  one-cycle pulse in the cycle the published outputs change.

## Operation

- States: IDLE, MUL, PENDING.
- **Reset.** State goes to IDLE. All `p*_inv`, all `dec_*`, `params_loaded` and `param_update` go to 0. Multiply and shadow registers are cleared. `in_ready` is 1.
- **Accept.** A set is accepted when `in_valid && in_ready`.
  - All nine `in_p*` are captured into shadow registers.
  - Accumulators for `in_p1`, `in_p4` and `in_p7` are cleared.
  - State goes to MUL and the iteration counter is set to 0.
- **MUL.** Runs `MUL_W` cycles. Iteration k, LSB first:
  - If bit k of `H_STEPS` is set, `acc += multiplicand << k`.
  - Multiplicands are sign-extended to the output width (79 or 71 bits).
  - Arithmetic is two's complement. No overflow is possible at the declared widths.
  - After iteration `MUL_W-1`, state goes to PENDING.
  - `in_ready` is 0 throughout MUL.
- **PENDING.** The complete shadow set waits for `frame_start`. `in_ready` is 1.
- **Publish.** On `frame_start` in PENDING, at the next edge:
  - all nine `p*_inv` and three `dec_*` load from shadow,
  - `param_update` pulses,
  - `params_loaded` is set and stays set until reset,
  - state goes to IDLE.
- **`frame_start` outside PENDING** (IDLE or MUL): outputs are unchanged and there is no pulse. A set still in MUL waits for the following `frame_start`.
- **Accept in PENDING, no `frame_start` that cycle:** the pending set is discarded (latest wins) and MUL restarts with the new set.
- **Accept in PENDING with `frame_start` in the same cycle:** the old pending set publishes and the new set is captured into shadow, entering MUL. Published outputs are taken from the shadow value before the overwrite.
- **`reset` mid-MUL or in PENDING:** the in-flight set is lost. Outputs return to 0 and `params_loaded` to 0.
- Published outputs never change except on a publish or on reset.

## Timing

- All outputs are registered. There are no combinational paths from input to output.
- `in_ready` is a registered function of state: 1 in IDLE and PENDING, 0 in MUL.
- Accept at edge T: MUL occupies cycles T+1..T+`MUL_W`, and state is PENDING at edge T+`MUL_W`+1. This is 11 cycles with default parameters.
- `frame_start` high in cycle F while PENDING: outputs and `param_update` change at edge F+1, which coincides with the `vga` frame reload edge.
- Minimum spacing between accepts is `MUL_W`+1 cycles.
- Rate limit: at most one publish per frame.

## Test plan

- **Reset values.** Assert `reset` 3 cycles with `in_valid=1` -> all outputs 0, `params_loaded=0`, `in_ready=1`, no accept.
- **Basic multiply and publish.** Accept `p1=3`, `p4=-2`, `p7=-5`, `p9=7`. Pulse `frame_start` 20 cycles later. Required response:
  - `dec_numx_horiz=2400`, `dec_numy_horiz=-1600`, `dec_denom_horiz=-4000`, `p9_inv=7`, one edge after `frame_start`;
  - `param_update` high for exactly 1 cycle.
- **Early `frame_start`.** Pulse `frame_start` 5 cycles after accept (in MUL) -> outputs unchanged, no pulse. The next `frame_start` publishes the set.
- **Latest wins.** Accept `p1=1`. In PENDING, accept `p1=2`. Then pulse `frame_start` after MUL completes -> `dec_numx_horiz=1600`; the value 800 is never published.
- **Simultaneous accept and publish.** In PENDING with `p1=1`, accept `p1=4` in the same cycle as `frame_start` -> `dec_numx_horiz=800` published now. The next `frame_start` after 11 cycles publishes 3200.
- **Extremes and mid-operation reset.**
  - `p1 = -2^67` -> `dec_numx_horiz = -800·2^67`, exact.
  - Reset during MUL -> state IDLE and outputs 0; the following `frame_start` publishes nothing.

Source files
------------

// File: rtl/persp_param_latch.sv
// rtl/persp_param_latch.sv - frame-synchronous latch for inverse-perspective coefficients and rewind terms
module persp_param_latch #(
  parameter int H_STEPS = 800,
  parameter int MUL_W   = 10
) (
  input  logic               vclock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [67:0] in_p1,
  input  logic signed [68:0] in_p2,
  input  logic signed [78:0] in_p3,
  input  logic signed [67:0] in_p4,
  input  logic signed [68:0] in_p5,
  input  logic signed [78:0] in_p6,
  input  logic signed [58:0] in_p7,
  input  logic signed [59:0] in_p8,
  input  logic signed [70:0] in_p9,
  input  logic               frame_start,
  output logic signed [67:0] p1_inv,
  output logic signed [68:0] p2_inv,
  output logic signed [78:0] p3_inv,
  output logic signed [67:0] p4_inv,
  output logic signed [68:0] p5_inv,
  output logic signed [78:0] p6_inv,
  output logic signed [58:0] p7_inv,
  output logic signed [59:0] p8_inv,
  output logic signed [70:0] p9_inv,
  output logic signed [78:0] dec_numx_horiz,
  output logic signed [78:0] dec_numy_horiz,
  output logic signed [70:0] dec_denom_horiz,
  output logic               params_loaded,
  output logic               param_update
);

  localparam int CNT_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;
  localparam logic [MUL_W-1:0] H_BITS = MUL_W'(H_STEPS);

  typedef enum logic [1:0] {IDLE, MUL, PENDING} state_t;

  state_t state, state_nxt;

  logic signed [67:0] sh_p1;
  logic signed [68:0] sh_p2;
  logic signed [78:0] sh_p3;
  logic signed [67:0] sh_p4;
  logic signed [68:0] sh_p5;
  logic signed [78:0] sh_p6;
  logic signed [58:0] sh_p7;
  logic signed [59:0] sh_p8;
  logic signed [70:0] sh_p9;

  logic signed [78:0] acc_x, acc_y, mc_x, mc_y;
  logic signed [70:0] acc_d, mc_d;
  logic [MUL_W-1:0]   mul_bits;
  logic [CNT_W-1:0]   cnt;

  logic accept, publish, mul_last;

  always_comb begin
    accept    = in_valid && in_ready;
    publish   = (state == PENDING) && frame_start;
    mul_last  = (state == MUL) && (cnt == CNT_W'(MUL_W - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MUL;
      MUL:     if (mul_last) state_nxt = PENDING;
      // a new set supersedes the pending one even when it publishes this cycle
      PENDING: if (accept) state_nxt = MUL;
               else if (publish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != MUL);
    end
  end

  // Shift-add multiply: multiplicand shifts left while the H_STEPS bits shift out LSB first
  always_ff @(posedge vclock) begin
    if (reset) begin
      sh_p1 <= '0; sh_p2 <= '0; sh_p3 <= '0;
      sh_p4 <= '0; sh_p5 <= '0; sh_p6 <= '0;
      sh_p7 <= '0; sh_p8 <= '0; sh_p9 <= '0;
      acc_x <= '0; acc_y <= '0; acc_d <= '0;
      mc_x  <= '0; mc_y  <= '0; mc_d  <= '0;
      mul_bits <= '0;
      cnt      <= '0;
    end else if (accept) begin
      sh_p1 <= in_p1; sh_p2 <= in_p2; sh_p3 <= in_p3;
      sh_p4 <= in_p4; sh_p5 <= in_p5; sh_p6 <= in_p6;
      sh_p7 <= in_p7; sh_p8 <= in_p8; sh_p9 <= in_p9;
      acc_x <= '0; acc_y <= '0; acc_d <= '0;
      mc_x  <= {{11{in_p1[67]}}, in_p1};
      mc_y  <= {{11{in_p4[67]}}, in_p4};
      mc_d  <= {{12{in_p7[58]}}, in_p7};
      mul_bits <= H_BITS;
      cnt      <= '0;
    end else if (state == MUL) begin
      if (mul_bits[0]) begin
        acc_x <= acc_x + mc_x;
        acc_y <= acc_y + mc_y;
        acc_d <= acc_d + mc_d;
      end
      mc_x     <= mc_x <<< 1;
      mc_y     <= mc_y <<< 1;
      mc_d     <= mc_d <<< 1;
      mul_bits <= mul_bits >> 1;
      cnt      <= cnt + CNT_W'(1);
    end
  end

  // Publish reads the shadow as it stood before any same-cycle accept overwrites it
  always_ff @(posedge vclock) begin
    if (reset) begin
      p1_inv <= '0; p2_inv <= '0; p3_inv <= '0;
      p4_inv <= '0; p5_inv <= '0; p6_inv <= '0;
      p7_inv <= '0; p8_inv <= '0; p9_inv <= '0;
      dec_numx_horiz  <= '0;
      dec_numy_horiz  <= '0;
      dec_denom_horiz <= '0;
      params_loaded   <= 1'b0;
      param_update    <= 1'b0;
    end else begin
      param_update <= publish;
      if (publish) begin
        p1_inv <= sh_p1; p2_inv <= sh_p2; p3_inv <= sh_p3;
        p4_inv <= sh_p4; p5_inv <= sh_p5; p6_inv <= sh_p6;
        p7_inv <= sh_p7; p8_inv <= sh_p8; p9_inv <= sh_p9;
        dec_numx_horiz  <= acc_x;
        dec_numy_horiz  <= acc_y;
        dec_denom_horiz <= acc_d;
        params_loaded   <= 1'b1;
      end
    end
  end

endmodule
